// File: rtl/simon_game_ctrl.sv
// Simon game controller: sequences the gap, show, input and check phases of a round.
// It steps the level after each passed round and reports a win or a loss.
// Optional feature: define SIMON_TIMEOUT_EN to make the controller lose the game
// when the player is inactive for TIMEOUT_CYCLES cycles in the input phase.
module simon_game_ctrl #(
  parameter logic [3:0]  MAX_LEVEL      = 4'd9,
  parameter int unsigned GAP_CYCLES     = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       blink_done,
  input  logic [3:0] blink_count,
  input  logic [1:0] mem_data,
  output logic       on_off,
  output logic [3:0] level,
  output logic [3:0] mem_addr,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StGap, StShow, StInput, StCheck, StWin, StLose
  } state_e;

  state_e          state_q, state_d;
  logic            start_q;
  logic [3:0]      btn_q;
  logic [3:0]      edge_q, edge_d;
  logic [3:0]      level_q, level_d;
  logic [3:0]      idx_q, idx_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic       start_rise;
  logic [3:0] btn_rise;
  logic [1:0] code;
  logic       code_ok;
  logic       timeout_hit;

  assign start_rise = start & ~start_q;
  assign btn_rise   = btn & ~btn_q;

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] to_q, to_d;

  // Inactivity counter: runs only while waiting for a press, cleared everywhere else.
  always_comb begin
    to_d = '0;
    if (state_q == StInput && btn_rise == 4'b0000) begin
      to_d = to_q + 1'b1;
    end
  end

  assign timeout_hit = (to_q == ToLast);

  // Inactivity counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Encode the captured edge vector; anything other than a single bit is a wrong press.
  always_comb begin
    code    = 2'd0;
    code_ok = 1'b1;
    case (edge_q)
      4'b0001: code = 2'd0;
      4'b0010: code = 2'd1;
      4'b0100: code = 2'd2;
      4'b1000: code = 2'd3;
      default: code_ok = 1'b0;
    endcase
  end

  // Next-state logic for the game FSM and its counters.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    edge_d  = edge_q;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (start_rise) begin
          state_d = StGap;
          level_d = 4'd0;
          idx_d   = 4'd0;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StShow;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StShow: begin
        if (blink_done) begin
          state_d = StInput;
          idx_d   = 4'd0;
        end
      end
      StInput: begin
        if (btn_rise != 4'b0000) begin
          edge_d  = btn_rise;
          state_d = StCheck;
        end else if (timeout_hit) begin
          state_d = StLose;
        end
      end
      StCheck: begin
        if (!code_ok || code != mem_data) begin
          state_d = StLose;
        end else if (idx_q < level_q) begin
          idx_d   = idx_q + 1'b1;
          state_d = StInput;
        end else if (level_q < MAX_LEVEL) begin
          level_d = level_q + 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          state_d = StWin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and edge-detect registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      btn_q   <= 4'b0000;
      edge_q  <= 4'b0000;
      level_q <= 4'd0;
      idx_q   <= 4'd0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      btn_q   <= btn;
      edge_q  <= edge_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decoded from the registered state; the blinker owns the address during SHOW.
  always_comb begin
    on_off   = (state_q == StShow);
    busy     = (state_q == StGap) || (state_q == StShow) ||
               (state_q == StInput) || (state_q == StCheck);
    win      = (state_q == StWin);
    lose     = (state_q == StLose);
    level    = level_q;
    mem_addr = (state_q == StShow) ? blink_count : idx_q;
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl (MAX_LEVEL=2, GAP_CYCLES=4, TIMEOUT_CYCLES=20,
// sequence memory 1,3,0). Define SIMON_TIMEOUT_EN to exercise the timeout build.
module tb_simon_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] btn;
  logic       blink_done;
  logic [3:0] blink_count;
  logic [1:0] mem_data;
  logic       on_off;
  logic [3:0] level;
  logic [3:0] mem_addr;
  logic       busy;
  logic       win;
  logic       lose;

  logic [1:0] mem [16];
  logic [3:0] bc = 4'd0;
  logic       bd = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit         new_round;
    logic [3:0] show_lvl;
    logic [3:0] mask;
    logic [3:0] lvl;
    logic       win;
    logic       lose;
    logic       busy;
  } step_t;

  step_t tbl [6];
  step_t sb [$];

  simon_game_ctrl #(
    .MAX_LEVEL      (4'd2),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .btn         (btn),
    .blink_done  (blink_done),
    .blink_count (blink_count),
    .mem_data    (mem_data),
    .on_off      (on_off),
    .level       (level),
    .mem_addr    (mem_addr),
    .busy        (busy),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  assign mem_data    = mem[mem_addr];
  assign blink_count = bc;
  assign blink_done  = bd;

  // Simple blinker: walks addresses 0..level while enabled, then raises done.
  always @(posedge clk) begin
    if (!on_off) begin
      bc <= 4'd0;
      bd <= 1'b0;
    end else if (bc == level) begin
      bd <= 1'b1;
    end else begin
      bc <= bc + 4'd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for the show phase, optionally hold buttons during it, return once in INPUT.
  task automatic wait_round(input logic [3:0] exp_lvl, input logic [3:0] hold);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      if (on_off) seen = 1'b1;
      n++;
    end
    chk("show_reached", int'(seen), 1);
    chk("show_level", int'(level), int'(exp_lvl));
    btn = hold;
    n = 0;
    while (on_off && n < 60) begin
      chk("mem_addr_follow", int'(mem_addr), int'(bc));
      @(negedge clk);
      n++;
    end
    chk("show_left", int'(on_off), 0);
  endtask

  // One-cycle button press from INPUT; returns lose one cycle after the edge.
  task automatic press(input logic [3:0] mask, output logic mid_lose);
    btn = mask;
    @(posedge clk);
    #1 btn = 4'b0000;
    mid_lose = lose;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step_t e;
    logic  ml;
    int    n;

    foreach (mem[i]) mem[i] = 2'd0;
    mem[0] = 2'd1;
    mem[1] = 2'd3;
    mem[2] = 2'd0;

    tbl[0] = '{1'b1, 4'd0, 4'b0010, 4'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 4'd1, 4'b0010, 4'd1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 4'd1, 4'b1000, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 4'd2, 4'b0010, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'd2, 4'b1000, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 4'd2, 4'b0001, 4'd2, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    btn   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_on_off", int'(on_off), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_lose", int'(lose), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Gap length, then reset in the middle of SHOW.
    start_pulse();
    chk("gap_busy", int'(busy), 1);
    chk("gap_on_off", int'(on_off), 0);
    n = 0;
    while (!on_off && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("gap_cycles", n, 4);
    chk("show_addr0", int'(mem_addr), int'(bc));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midshow_rst_on_off", int'(on_off), 0);
    chk("midshow_rst_level", int'(level), 0);
    chk("midshow_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_rst", int'(busy), 0);

    // Full correct game, table driven with a scoreboard.
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].new_round) wait_round(tbl[i].show_lvl, 4'b0000);
      sb.push_back(tbl[i]);
      press(tbl[i].mask, ml);
      e = sb.pop_front();
      chk($sformatf("play%0d_level", i), int'(level), int'(e.lvl));
      chk($sformatf("play%0d_win", i), int'(win), int'(e.win));
      chk($sformatf("play%0d_lose", i), int'(lose), int'(e.lose));
      chk($sformatf("play%0d_busy", i), int'(busy), int'(e.busy));
    end

    // Wrong button at level 1, then restart clears the loss.
    start_pulse();
    chk("restart_win_clr", int'(win), 0);
    wait_round(4'd0, 4'b0000);
    press(4'b0010, ml);
    chk("l1_level", int'(level), 1);
    wait_round(4'd1, 4'b0000);
    press(4'b0100, ml);
    chk("wrong_mid_lose", int'(ml), 0);
    chk("wrong_lose", int'(lose), 1);
    chk("wrong_busy", int'(busy), 0);
    chk("wrong_level_held", int'(level), 1);
    start_pulse();
    chk("restart_lose_clr", int'(lose), 0);
    chk("restart_level", int'(level), 0);
    chk("restart_busy", int'(busy), 1);

    // Two buttons rising together count as wrong.
    wait_round(4'd0, 4'b0000);
    press(4'b1010, ml);
    chk("multi_lose", int'(lose), 1);

    // Button held across INPUT entry is not a press.
    start_pulse();
    wait_round(4'd0, 4'b0010);
    repeat (10) @(posedge clk);
    #1;
    chk("held_lose", int'(lose), 0);
    chk("held_busy", int'(busy), 1);
    chk("held_level", int'(level), 0);
    btn = 4'b0000;
    @(posedge clk);
    #1;
    press(4'b0010, ml);
    chk("after_held_level", int'(level), 1);
    chk("after_held_lose", int'(lose), 0);

    // Inactivity in INPUT.
    wait_round(4'd1, 4'b0000);
    n = 0;
`ifdef SIMON_TIMEOUT_EN
    while (!lose && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout_cycles", n, 20);
    chk("timeout_lose", int'(lose), 1);
`else
    repeat (100) @(posedge clk);
    #1;
    chk("no_timeout_lose", int'(lose), 0);
    chk("no_timeout_busy", int'(busy), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 4'd9, meaning final level index; a round at this level passed means game won; legal range 0..9.
REQ-002 SHALL have parameter GAP_CYCLES, default 25_000_000, meaning on_off-low cycles between rounds (0.5 s at 50 MHz); minimum 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250_000_000, meaning player inactivity limit (5 s); used only with SIMON_TIMEOUT_EN.
REQ-004 SHALL have clk  in  1  single system clock; all logic on posedge clk.
REQ-005 SHALL have reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have start  in  1  level, begin/restart game; rising edge detected internally.
REQ-007 SHALL have btn  in  4  player buttons, one bit per LED, active-high, pre-debounced.
REQ-008 SHALL have blink_done  in  1  blinker finished showing the sequence.
REQ-009 SHALL have blink_count  in  4  blinker's memory address.
REQ-010 SHALL have mem_data  in  2  sequence entry read at mem_addr, combinational memory.
REQ-011 SHALL have on_off  out  1  blinker enable.
REQ-012 SHALL have level  out  4  current level to blinker; round length = level+1.
REQ-013 SHALL have mem_addr  out  4  shared memory address.
REQ-014 SHALL have busy, win, lose  out  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, GAP, SHOW, INPUT, CHECK, WIN, LOSE; registered, one transition per clk.
REQ-016 IDLE: start rising edge -> GAP with level=0, gap counter cleared.
REQ-017 GAP: on_off=0; after exactly GAP_CYCLES cycles in GAP -> SHOW.
REQ-018 SHOW: on_off=1; blink_done=1 -> INPUT, on_off=0 from the next cycle, input_idx=0.
REQ-019 mem_addr SHALL be blink_count in SHOW and input_idx in all other states (combinational mux).
REQ-020 INPUT: btn rising edges detected against a 1-cycle-delayed copy; the edge vector is registered and evaluated in CHECK on the following cycle.
REQ-021 Exactly one bit rising -> encoded 0..3 (bit0=0 ... bit3=3); two or more bits rising in the same cycle SHALL count as wrong.
REQ-022 CHECK: code != mem_data -> LOSE; code == mem_data and input_idx < level -> input_idx+1, back to INPUT; code == mem_data and input_idx == level -> round passed.
REQ-023 Round passed with level < MAX_LEVEL -> level+1, GAP; with level == MAX_LEVEL -> WIN; level never exceeds MAX_LEVEL.
REQ-024 Buttons already held on entry to INPUT SHALL NOT count as presses; only 0->1 transitions count.
REQ-025 WIN/LOSE: flag held high, on_off=0, level held; start rising edge -> GAP with level=0, flags cleared.
REQ-026 start SHALL be ignored in GAP, SHOW, INPUT, CHECK.
REQ-027 busy SHALL be 1 in GAP, SHOW, INPUT, CHECK; 0 in IDLE, WIN, LOSE.
REQ-028 Counters SHALL be wide enough for their parameter; no wrap before terminal count.

Reset
REQ-029 reset=0 at posedge clk SHALL force state IDLE, on_off=0, level=0, input_idx=0, win=0, lose=0, busy=0, counters 0, edge registers 0, from any state including mid-SHOW.
REQ-030 On release, the first start rising edge SHALL be detected relative to start sampled low after reset.

Configuration
REQ-031 Macro SIMON_TIMEOUT_EN defined: INPUT counts cycles since entering INPUT or since the last accepted press; reaching TIMEOUT_CYCLES -> LOSE.
REQ-032 Macro SIMON_TIMEOUT_EN undefined: no timeout counter; INPUT waits indefinitely.

Verification (MAX_LEVEL=2, GAP_CYCLES=4, TIMEOUT_CYCLES=20, memory = 1,3,0)
REQ-033 Reset low 3 cycles mid-SHOW -> next cycle IDLE, on_off=0, level=0, busy=0.
REQ-034 start pulse -> on_off rises exactly 4 cycles after GAP entry; mem_addr follows blink_count while on_off=1.
REQ-035 Full correct play (btn1; btn1,btn3; btn1,btn3,btn0) -> level steps 0,1,2, then win=1, lose=0, busy=0.
REQ-036 Level 1, press btn2 for the first entry -> lose=1 two cycles after the edge; a start pulse then clears lose and sets level=0.
REQ-037 btn1 and btn3 rise in the same cycle -> lose=1; btn1 held through INPUT entry, no other press -> no CHECK, stays INPUT.
REQ-038 With SIMON_TIMEOUT_EN: no press for 20 cycles in INPUT -> lose=1; without it, after 100 idle cycles still in INPUT, lose=0.
